// File: rtl/im_fetch_arbiter.sv
// Program-counter owner and instruction-memory arbiter: boot-time image loader,
// PC sequencing and fair sharing of the write port with a run-time loader.
module im_fetch_arbiter #(
    parameter logic [31:0] RESET_PC     = 32'h0000_3000,
    parameter bit          BOOT_LOAD    = 1'b1,
    parameter int          AW           = 10,
    parameter int          STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    input  logic          redirect,
    input  logic [31:0]   redirect_pc,
    output logic [31:0]   pc,
    output logic [AW-1:0] im_addr,
    output logic          instr_valid,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [31:0]   ld_addr,
    input  logic [31:0]   ld_data,
    input  logic          ld_last,
    output logic          im_we,
    output logic [AW-1:0] im_waddr,
    output logic [31:0]   im_wdata,
    output logic          loading,
    output logic [AW:0]   ld_count,
    output logic          ld_err,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam state_t      RESET_STATE = BOOT_LOAD ? ST_LOAD : ST_RUN;
    localparam logic [AW:0] CNT_MAX     = {1'b1, {AW{1'b0}}};
    localparam logic [3:0]  LIMIT_M1    = 4'(STARVE_LIMIT - 1);

    state_t        r_state;
    logic [31:0]   r_pc;
    logic          r_im_we;
    logic [AW-1:0] r_im_waddr;
    logic [31:0]   r_im_wdata;
    logic [AW:0]   r_ld_count;
    logic          r_ld_err;
    logic [3:0]    r_starve_cnt;
    logic          r_force_q;

    logic          w_ld_ready;
    logic          w_accept;
    logic          w_aligned;
    logic          w_denied;
    logic          w_starve_hit;
    logic [31:0]   w_pc_next;
    logic          w_unused_bits;

    // Loader handshake: a beat transfers in any cycle where ld_valid and
    // ld_ready are both high; ld_ready never depends on ld_valid.
    always_comb begin
        w_ld_ready = 1'b0;
        case (r_state)
            ST_LOAD:  w_ld_ready = 1'b1;
            ST_DRAIN: w_ld_ready = 1'b0;
            ST_RUN:   w_ld_ready = stall | r_force_q;
            default:  w_ld_ready = 1'b0;
        endcase
    end

    assign w_accept  = ld_valid & w_ld_ready;
    assign w_aligned = (ld_addr[1:0] == 2'b00);
    assign w_denied  = (r_state == ST_RUN) & ld_valid & ~w_ld_ready;
    // Hit when this denial brings the run of consecutive denials to the limit.
    assign w_starve_hit = w_denied & (r_starve_cnt >= LIMIT_M1);

    always_comb begin
        w_pc_next = r_pc + 32'd4;
        if (redirect) begin
            w_pc_next = {redirect_pc[31:2], 2'b00};
        end else if (r_force_q || stall) begin
            w_pc_next = r_pc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= RESET_STATE;
            r_pc         <= RESET_PC;
            r_im_we      <= 1'b0;
            r_im_waddr   <= '0;
            r_im_wdata   <= '0;
            r_ld_count   <= '0;
            r_ld_err     <= 1'b0;
            r_starve_cnt <= 4'd0;
            r_force_q    <= 1'b0;
        end else begin
            r_im_we   <= w_accept & w_aligned;
            r_force_q <= 1'b0;
            if (w_accept && w_aligned) begin
                r_im_waddr <= ld_addr[AW+1:2];
                r_im_wdata <= ld_data;
            end
            if (w_accept && !w_aligned) begin
                r_ld_err <= 1'b1;
            end
            case (r_state)
                ST_LOAD: begin
                    r_pc         <= RESET_PC;
                    r_starve_cnt <= 4'd0;
                    if (w_accept && w_aligned && (r_ld_count != CNT_MAX)) begin
                        r_ld_count <= r_ld_count + (AW+1)'(1);
                    end
                    if (w_accept && ld_last) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    r_pc         <= RESET_PC;
                    r_starve_cnt <= 4'd0;
                    r_state      <= ST_RUN;
                end
                ST_RUN: begin
                    r_pc <= w_pc_next;
                    if (w_denied) begin
                        if (r_starve_cnt != 4'hF) begin
                            r_starve_cnt <= r_starve_cnt + 4'd1;
                        end
                    end else begin
                        r_starve_cnt <= 4'd0;
                    end
                    // A redirect cycle defers the bubble; the still-saturated
                    // counter re-requests it on the next denied cycle.
                    r_force_q <= w_starve_hit & ~redirect;
                end
                default: begin
                    r_state <= RESET_STATE;
                end
            endcase
        end
    end

    assign pc          = r_pc;
    assign im_addr     = r_pc[AW+1:2];
    assign instr_valid = (r_state == ST_RUN) & ~r_force_q;
    assign ld_ready    = w_ld_ready;
    assign im_we       = r_im_we;
    assign im_waddr    = r_im_waddr;
    assign im_wdata    = r_im_wdata;
    assign loading     = (r_state == ST_LOAD) | (r_state == ST_DRAIN);
    assign ld_count    = r_ld_count;
    assign ld_err      = r_ld_err;
    assign dbg_state   = r_state;

    assign w_unused_bits = &{1'b0, ld_addr[31:AW+2], redirect_pc[1:0]};

endmodule
